// File: rtl/axi4l_cmd_master_if.sv
// rtl/axi4l_cmd_master_if.sv - AXI4-Lite bus bundle between the command master and a responder
//
// Purpose: carries the five AXI4-Lite channels (AW, W, B, AR, R) as one port.
// Modports:
//   master - initiator side: drives aw*/w*/ar* payload+valid and bready/rready
//   slave  - responder side: drives awready/wready/arready and b*/r* payload+valid
interface axi4l_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4l_cmd_master.sv
// rtl/axi4l_cmd_master.sv - AXI4-Lite initiator turning single-beat local commands into bus reads/writes
//
// Purpose: accepts one command at a time on the cmd_* port, performs the AXI4-Lite
// read or write, and returns the result on the rsp_* port. One transaction outstanding.
// Optional watchdog: define AXI4L_MST_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES cycles with rsp_resp=2'b10 and rsp_timeout=1.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/addr/wdata/wstrb     command payload (1=write, 0=read)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_resp/rsp_timeout response payload (rdata=0 for writes)
//   axi                            AXI4-Lite master side of axi4l_cmd_master_if
module axi4l_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    axi4l_cmd_master_if.master      axi
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("axi4l_cmd_master: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi4l_cmd_master: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WR_RSP = 3'd2,
        RD_REQ = 3'd3,
        RD_RSP = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // live_q holds cmd_ready low until the first clock after reset release.
    logic                    live_q;
    logic                    aw_done_q;
    logic                    w_done_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;

    logic accept;
    logic aw_fire;
    logic w_fire;
    logic ar_fire;
    logic b_fire;
    logic r_fire;
    logic tmo_hit;

    // Handshakes derived from state so the valid/ready outputs never loop back combinationally.
    assign accept  = (state_q == IDLE)   && live_q && cmd_valid;
    assign aw_fire = (state_q == WR_REQ) && !aw_done_q && axi.awready;
    assign w_fire  = (state_q == WR_REQ) && !w_done_q  && axi.wready;
    assign ar_fire = (state_q == RD_REQ) && axi.arready;
    assign b_fire  = (state_q == WR_RSP) && axi.bvalid;
    assign r_fire  = (state_q == RD_RSP) && axi.rvalid;

`ifdef AXI4L_MST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] timer_q;
    logic          in_flight;
    logic          rsp_timeout_q;

    assign in_flight = (state_q == WR_REQ) || (state_q == WR_RSP) ||
                       (state_q == RD_REQ) || (state_q == RD_RSP);
    // Fires on the last of TIMEOUT_CYCLES active cycles; a response arriving in
    // that same cycle still wins.
    assign tmo_hit   = in_flight && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q       <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                timer_q       <= '0;
                rsp_timeout_q <= 1'b0;
            end else if (in_flight) begin
                timer_q <= timer_q + TW'(1);
            end
            if (tmo_hit && !b_fire && !r_fire) begin
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign tmo_hit     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = live_q;
                if (accept) begin
                    state_d = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both have been taken.
                axi.awvalid = !aw_done_q;
                axi.wvalid  = !w_done_q;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = WR_RSP;
                end
            end
            WR_RSP: begin
                axi.bready = 1'b1;
                if (b_fire) begin
                    state_d = DONE;
                end
            end
            RD_REQ: begin
                axi.arvalid = 1'b1;
                if (ar_fire) begin
                    state_d = RD_RSP;
                end
            end
            RD_RSP: begin
                axi.rready = 1'b1;
                if (r_fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (tmo_hit && !b_fire && !r_fire) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live_q      <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_fire) begin
                aw_done_q <= 1'b1;
            end
            if (w_fire) begin
                w_done_q <= 1'b1;
            end
            if (b_fire) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= axi.bresp;
            end
            if (r_fire) begin
                rsp_rdata_q <= axi.rdata;
                rsp_resp_q  <= axi.rresp;
            end
            if (tmo_hit && !b_fire && !r_fire) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= 2'b10;
            end
        end
    end

    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_resp   = rsp_resp_q;

    assign axi.awaddr = addr_q;
    assign axi.awprot = 3'b000;
    assign axi.wdata  = wdata_q;
    assign axi.wstrb  = wstrb_q;
    assign axi.araddr = addr_q;
    assign axi.arprot = 3'b000;

endmodule

// File: tb/tb_axi4l_cmd_master.sv
// tb/tb_axi4l_cmd_master.sv - self-checking bench for axi4l_cmd_master
module tb_axi4l_cmd_master;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;
`ifdef AXI4L_MST_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    axi4l_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4l_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .axi         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.arready = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
    endtask

    // One complete transaction against a responder that waits a_wait/w_wait cycles
    // before accepting AW(AR)/W and r_wait cycles before presenting B/R.
    // Called and returns just after a falling edge.
    task automatic run_txn(input string nm, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int a_wait, input int w_wait, input int r_wait,
                           input logic [1:0] resp, input int hold);
        int          cyc;
        int          a_cnt;
        int          w_cnt;
        int          r_cnt;
        int          lat_full;
        int          lat_exp;
        bit          a_done;
        bit          w_done;
        bit          a_fire;
        bit          w_fire;
        bit          rsp_phase;
        bit          timed_out;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;

        a_cnt  = 0;
        w_cnt  = 0;
        r_cnt  = 0;
        a_done = 1'b0;
        w_done = !wr;
        lat_full  = wr ? ((a_wait > w_wait ? a_wait : w_wait) + r_wait + 3) : (a_wait + r_wait + 3);
        timed_out = TMO_EN && ((lat_full - 1) > TMO);
        lat_exp   = timed_out ? (TMO + 1) : lat_full;
        exp_rdata = (wr || timed_out) ? 32'h0 : data;
        exp_resp  = timed_out ? 2'b10 : resp;

        check({nm, "/cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_wstrb = 4'($urandom);

        for (cyc = 1; cyc < 64; cyc++) begin
            if (rsp_valid) break;
            rsp_phase = a_done && w_done;
            check({nm, "/cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
            check({nm, "/awvalid"}, 64'(bus.awvalid), 64'(wr && !a_done));
            check({nm, "/wvalid"},  64'(bus.wvalid),  64'(wr && !w_done));
            check({nm, "/arvalid"}, 64'(bus.arvalid), 64'(!wr && !a_done));
            check({nm, "/bready"},  64'(bus.bready),  64'(wr && rsp_phase));
            check({nm, "/rready"},  64'(bus.rready),  64'(!wr && rsp_phase));
            check({nm, "/prot"},    64'({bus.awprot, bus.arprot}), 64'd0);
            idle_bus();
            a_fire = 1'b0;
            w_fire = 1'b0;
            if (!a_done) begin
                if (wr) check({nm, "/awaddr"}, 64'(bus.awaddr), 64'(addr));
                else    check({nm, "/araddr"}, 64'(bus.araddr), 64'(addr));
                a_fire = (a_cnt >= a_wait);
                a_cnt++;
                if (wr) bus.awready = a_fire;
                else    bus.arready = a_fire;
            end
            if (!w_done) begin
                check({nm, "/wdata"}, 64'(bus.wdata), 64'(data));
                check({nm, "/wstrb"}, 64'(bus.wstrb), 64'(strb));
                w_fire = (w_cnt >= w_wait);
                w_cnt++;
                bus.wready = w_fire;
            end
            if (rsp_phase) begin
                if (r_cnt >= r_wait) begin
                    if (wr) begin
                        bus.bvalid = 1'b1;
                        bus.bresp  = resp;
                    end else begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = data;
                        bus.rresp  = resp;
                    end
                end
                r_cnt++;
            end else if (wr) begin
                bus.bvalid = 1'($urandom_range(0, 1));
                bus.bresp  = 2'($urandom);
            end else begin
                bus.rvalid = 1'($urandom_range(0, 1));
                bus.rdata  = $urandom;
                bus.rresp  = 2'($urandom);
            end
            // Stray beats on the channel this transaction does not use.
            if (wr) begin
                bus.rvalid = 1'($urandom_range(0, 1));
                bus.rdata  = $urandom;
                bus.rresp  = 2'($urandom);
            end else begin
                bus.bvalid = 1'($urandom_range(0, 1));
                bus.bresp  = 2'($urandom);
            end
            @(posedge clk);
            if (a_fire) a_done = 1'b1;
            if (w_fire) w_done = 1'b1;
            @(negedge clk);
        end
        check({nm, "/latency"}, 64'(cyc), 64'(lat_exp));

        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (h == hold);
            check({nm, "/rsp_valid"},   64'(rsp_valid),   64'd1);
            check({nm, "/rsp_rdata"},   64'(rsp_rdata),   64'(exp_rdata));
            check({nm, "/rsp_resp"},    64'(rsp_resp),    64'(exp_resp));
            check({nm, "/rsp_timeout"}, 64'(rsp_timeout), 64'(timed_out));
            check({nm, "/cmd_ready_done"}, 64'(cmd_ready), 64'd0);
            check({nm, "/bus_quiet"},
                  64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 64'd0);
            idle_bus();
            bus.bvalid = 1'b1;
            bus.bresp  = 2'($urandom);
            bus.rvalid = 1'b1;
            bus.rdata  = $urandom;
            bus.rresp  = 2'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        idle_bus();
        check({nm, "/rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
        check({nm, "/cmd_ready_back"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        idle_bus();

        repeat (2) @(negedge clk);
        check("reset/cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset/valids",
              64'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid}), 64'd0);
        check("reset/rsp_rdata",   64'(rsp_rdata),   64'd0);
        check("reset/rsp_resp",    64'(rsp_resp),    64'd0);
        check("reset/rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("reset/prot",        64'({bus.awprot, bus.arprot}), 64'd0);
        rstn = 1'b1;
        #1;
        check("reset/cmd_ready_at_release", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset/cmd_ready_after", 64'(cmd_ready), 64'd1);

        run_txn("wr_basic",   1'b1, 32'h0000_0004, 32'h0000_00A5, 4'hF, 0, 0, 0, 2'b00, 0);
        run_txn("rd_wait5",   1'b0, 32'h0000_0000, 32'h0000_0011, 4'h0, 0, 0, 5, 2'b00, 0);
        run_txn("wr_w_first", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3, 4, 0, 1, 2'b01, 1);
        run_txn("wr_aw_first",1'b1, 32'h0000_0014, 32'h1234_5678, 4'hC, 0, 4, 0, 2'b11, 0);
        run_txn("rd_err_hold",1'b0, 32'h0000_0008, 32'hCAFE_0001, 4'h0, 1, 0, 0, 2'b10, 6);

        // Reset while a write sits in WR_REQ with awvalid high.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h0BAD_F00D;
        cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_mid/awvalid_before", 64'(bus.awvalid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid/aw_w_valid", 64'({bus.awvalid, bus.wvalid}), 64'd0);
        check("rst_mid/cmd_ready",  64'(cmd_ready), 64'd0);
        check("rst_mid/rsp_valid",  64'(rsp_valid), 64'd0);
        check("rst_mid/rsp_fields", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_mid/cmd_ready_release", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid/cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("rst_mid/awvalid_after",   64'(bus.awvalid), 64'd0);

        run_txn("rd_after_rst", 1'b0, 32'h0000_0044, 32'h7777_0000, 4'h0, 0, 0, 0, 2'b00, 0);

`ifdef AXI4L_MST_TIMEOUT_EN
        run_txn("rd_timeout", 1'b0, 32'h0000_0020, 32'h0000_0055, 4'h0, 1000, 0, 0, 2'b00, 2);
        run_txn("wr_timeout", 1'b1, 32'h0000_0024, 32'h0000_0066, 4'h1, 1000, 0, 0, 2'b00, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            run_txn("rand", 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                    4'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 5)), 2'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog expired");
    end

endmodule
